// File: rtl/ttt_game_sequencer.sv
// Tic-tac-toe turn sequencer: owns the board, alternates X/O moves over a
// valid/ready handshake, and ends the game on win, draw or turn timeout.
module ttt_game_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMER_W        = 16,
  parameter bit          X_STARTS       = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        move_valid,
  input  logic [3:0]  move_pos,
  output logic        move_ready,
  output logic [17:0] board,
  input  logic        win_in,
  input  logic [1:0]  who_in,
  output logic [1:0]  turn,
  output logic        illegal,
  output logic [3:0]  move_count,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        draw,
  output logic        timeout
);

  localparam logic [1:0] MARK_NONE = 2'b00;
  localparam logic [1:0] MARK_X    = 2'b01;
  localparam logic [1:0] MARK_O    = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_MOVE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t               state_q;
  logic [17:0]          board_q;
  logic [1:0]           turn_q;
  logic [3:0]           move_count_q;
  logic [TIMER_W-1:0]   timer_q;
  logic                 move_ready_q;
  logic                 illegal_q;
  logic                 game_over_q;
  logic [1:0]           winner_q;
  logic                 draw_q;
  logic                 timeout_q;

  logic [TIMER_W-1:0]   timer_d;
  logic                 handshake;
  logic                 cell_free;
  logic                 expire;
  logic                 bad_cell;
  logic [1:0]           opponent;

  // Positions outside 1..9 never match a cell, so they read as not free.
  always_comb begin
    cell_free = 1'b0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (move_pos == 4'(k + 1)) cell_free = (board_q[2*k +: 2] == MARK_NONE);
    end
  end

  always_comb begin
    handshake = move_valid & move_ready_q;
    timer_d   = timer_q + TIMER_W'(1);
    expire    = (TIMEOUT_CYCLES != 0) && (timer_d == TIMER_W'(TIMEOUT_CYCLES));
    opponent  = (turn_q == MARK_X) ? MARK_O : MARK_X;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      board_q      <= '0;
      turn_q       <= MARK_NONE;
      move_count_q <= '0;
      timer_q      <= '0;
      move_ready_q <= 1'b0;
      illegal_q    <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= MARK_NONE;
      draw_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_WAIT_MOVE;
            board_q      <= '0;
            move_count_q <= '0;
            timer_q      <= '0;
            game_over_q  <= 1'b0;
            winner_q     <= MARK_NONE;
            draw_q       <= 1'b0;
            timeout_q    <= 1'b0;
            turn_q       <= X_STARTS ? MARK_X : MARK_O;
            move_ready_q <= 1'b1;
          end
        end
        S_WAIT_MOVE: begin
          if (handshake && cell_free) begin
            for (int unsigned k = 0; k < 9; k++) begin
              if (move_pos == 4'(k + 1)) board_q[2*k +: 2] <= turn_q;
            end
            move_count_q <= move_count_q + 4'd1;
            move_ready_q <= 1'b0;
            state_q      <= S_CHECK;
          end else begin
            if (handshake) illegal_q <= 1'b1;
            // A legal move in the expiry cycle took the branch above instead.
            if (expire) begin
              state_q      <= S_DONE;
              game_over_q  <= 1'b1;
              winner_q     <= opponent;
              timeout_q    <= 1'b1;
              turn_q       <= MARK_NONE;
              move_ready_q <= 1'b0;
            end else begin
              timer_q <= timer_d;
            end
          end
        end
        S_CHECK: begin
          if (win_in) begin
            state_q     <= S_DONE;
            game_over_q <= 1'b1;
            winner_q    <= who_in;
            turn_q      <= MARK_NONE;
          end else if (move_count_q == 4'd9) begin
            state_q     <= S_DONE;
            game_over_q <= 1'b1;
            draw_q      <= 1'b1;
            winner_q    <= MARK_NONE;
            turn_q      <= MARK_NONE;
          end else begin
            state_q      <= S_WAIT_MOVE;
            turn_q       <= opponent;
            timer_q      <= '0;
            move_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign move_ready = move_ready_q;
  assign board      = board_q;
  assign turn       = turn_q;
  assign illegal    = illegal_q;
  assign move_count = move_count_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign draw       = draw_q;
  assign timeout    = timeout_q;

  always_comb begin
    bad_cell = 1'b0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (board_q[2*k +: 2] == 2'b11) bad_cell = 1'b1;
    end
  end

  a_count_max: assert property (@(posedge clock) disable iff (reset)
    move_count_q <= 4'd9);
  a_win_xor_draw: assert property (@(posedge clock) disable iff (reset)
    !(draw_q && (winner_q != MARK_NONE)));
  a_no_code_11: assert property (@(posedge clock) disable iff (reset)
    !bad_cell);

endmodule

// File: tb/tb_ttt_game_sequencer.sv
// Directed bench for ttt_game_sequencer: one instance without timeout and one
// with an 8-cycle turn timeout, both fed the same stimulus.
module tb_ttt_game_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        move_valid;
  logic [3:0]  move_pos;
  logic        win_in;
  logic [1:0]  who_in;

  logic        move_ready,   move_ready_t;
  logic [17:0] board,        board_t;
  logic [1:0]  turn,         turn_t;
  logic        illegal,      illegal_t;
  logic [3:0]  move_count,   move_count_t;
  logic        game_over,    game_over_t;
  logic [1:0]  winner,       winner_t;
  logic        draw,         draw_t;
  logic        timeout,      timeout_t;

  int unsigned vectors;
  int unsigned miscompares;

  ttt_game_sequencer #(.TIMEOUT_CYCLES(0), .TIMER_W(16), .X_STARTS(1'b1)) dut (
    .clock(clock), .reset(reset), .start(start), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready), .board(board),
    .win_in(win_in), .who_in(who_in), .turn(turn), .illegal(illegal),
    .move_count(move_count), .game_over(game_over), .winner(winner),
    .draw(draw), .timeout(timeout)
  );

  ttt_game_sequencer #(.TIMEOUT_CYCLES(8), .TIMER_W(16), .X_STARTS(1'b1)) dut_t (
    .clock(clock), .reset(reset), .start(start), .move_valid(move_valid),
    .move_pos(move_pos), .move_ready(move_ready_t), .board(board_t),
    .win_in(win_in), .who_in(who_in), .turn(turn_t), .illegal(illegal_t),
    .move_count(move_count_t), .game_over(game_over_t), .winner(winner_t),
    .draw(draw_t), .timeout(timeout_t)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a move for one edge, then let the CHECK cycle sample win_in/who_in.
  task automatic play(input logic [3:0] pos, input logic w, input logic [1:0] who);
    move_valid = 1'b1;
    move_pos   = pos;
    tick();
    move_valid = 1'b0;
    win_in     = w;
    who_in     = who;
    tick();
    win_in     = 1'b0;
    who_in     = 2'b00;
  endtask

  task automatic restart();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [3:0] bad_pos  [3];
    logic [3:0] draw_seq [9];
    bad_pos  = '{4'd1, 4'd0, 4'd12};
    draw_seq = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd4, 4'd7, 4'd6, 4'd9, 4'd8};
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; start = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
    win_in = 1'b0; who_in = 2'b00;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_board",     32'(board),      32'h0);
    chk("rst_count",     32'(move_count), 32'h0);
    chk("rst_turn",      32'(turn),       32'h0);
    chk("rst_ready",     32'(move_ready), 32'h0);
    chk("rst_game_over", 32'(game_over),  32'h0);

    // Win game: X 1,2,3 / O 4,5
    start = 1'b1; tick(); start = 1'b0;
    chk("start_turn",  32'(turn),       32'h1);
    chk("start_ready", 32'(move_ready), 32'h1);
    move_valid = 1'b1; move_pos = 4'd1; tick(); move_valid = 1'b0;
    chk("m1_ready_low", 32'(move_ready), 32'h0);
    chk("m1_board",     32'(board),      32'h1);
    chk("m1_count",     32'(move_count), 32'h1);
    tick();
    chk("m1_turn_o",    32'(turn),       32'h2);
    chk("m1_ready_hi",  32'(move_ready), 32'h1);
    play(4'd4, 1'b0, 2'b00);
    play(4'd2, 1'b0, 2'b00);
    play(4'd5, 1'b0, 2'b00);
    play(4'd3, 1'b1, 2'b01);
    chk("win_game_over", 32'(game_over),  32'h1);
    chk("win_winner",    32'(winner),     32'h1);
    chk("win_count",     32'(move_count), 32'h5);
    chk("win_board",     32'(board),      32'h295);
    chk("win_turn",      32'(turn),       32'h0);
    chk("win_ready",     32'(move_ready), 32'h0);
    chk("win_draw",      32'(draw),       32'h0);
    tick(); tick();
    chk("done_hold_over",  32'(game_over), 32'h1);
    chk("done_hold_board", 32'(board),     32'h295);

    // Start from DONE with a simultaneous move, which must be dropped
    start = 1'b1; move_valid = 1'b1; move_pos = 4'd5; tick();
    start = 1'b0; move_valid = 1'b0;
    chk("rs_game_over", 32'(game_over),  32'h0);
    chk("rs_winner",    32'(winner),     32'h0);
    chk("rs_board",     32'(board),      32'h0);
    chk("rs_count",     32'(move_count), 32'h0);
    chk("rs_turn",      32'(turn),       32'h1);
    tick();
    chk("rs_move_ignored", 32'(board), 32'h0);

    // Illegal attempts by O
    play(4'd1, 1'b0, 2'b00);
    chk("il_turn_o", 32'(turn), 32'h2);
    for (int i = 0; i < 3; i++) begin
      move_valid = 1'b1; move_pos = bad_pos[i]; tick(); move_valid = 1'b0;
      chk("il_pulse", 32'(illegal),    32'h1);
      chk("il_board", 32'(board),      32'h1);
      chk("il_count", 32'(move_count), 32'h1);
      chk("il_turn",  32'(turn),       32'h2);
      tick();
      chk("il_single", 32'(illegal), 32'h0);
    end
    play(4'd9, 1'b0, 2'b00);
    chk("il_after_board", 32'(board),      32'h20001);
    chk("il_after_count", 32'(move_count), 32'h2);
    chk("il_after_turn",  32'(turn),       32'h1);

    // Full-board draw
    restart();
    for (int i = 0; i < 9; i++) play(draw_seq[i], 1'b0, 2'b00);
    chk("dr_draw",      32'(draw),       32'h1);
    chk("dr_winner",    32'(winner),     32'h0);
    chk("dr_count",     32'(move_count), 32'h9);
    chk("dr_ready",     32'(move_ready), 32'h0);
    chk("dr_game_over", 32'(game_over),  32'h1);
    chk("dr_board",     32'(board),      32'h26659);

    // Timeout: X idle for 8 cycles
    restart();
    repeat (7) tick();
    chk("to_not_yet",  32'(game_over_t),  32'h0);
    chk("to_ready",    32'(move_ready_t), 32'h1);
    tick();
    chk("to_done",     32'(game_over_t),  32'h1);
    chk("to_flag",     32'(timeout_t),    32'h1);
    chk("to_winner",   32'(winner_t),     32'h2);
    chk("to_turn",     32'(turn_t),       32'h0);
    chk("to_disabled", 32'(game_over),    32'h0);
    chk("to_dis_rdy",  32'(move_ready),   32'h1);

    // Legal move on the expiry cycle beats the timeout
    restart();
    repeat (7) tick();
    move_valid = 1'b1; move_pos = 4'd5; tick(); move_valid = 1'b0;
    chk("tm_count",   32'(move_count_t), 32'h1);
    chk("tm_no_to",   32'(timeout_t),    32'h0);
    chk("tm_no_over", 32'(game_over_t),  32'h0);
    chk("tm_board",   32'(board_t),      32'h100);
    tick();
    chk("tm_turn",    32'(turn_t),       32'h2);
    chk("tm_ready",   32'(move_ready_t), 32'h1);

    // Reset mid-game
    restart();
    play(4'd1, 1'b0, 2'b00);
    play(4'd2, 1'b0, 2'b00);
    play(4'd3, 1'b0, 2'b00);
    play(4'd4, 1'b0, 2'b00);
    chk("mr_count4", 32'(move_count), 32'h4);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mr_board",   32'(board),      32'h0);
    chk("mr_count",   32'(move_count), 32'h0);
    chk("mr_turn",    32'(turn),       32'h0);
    chk("mr_ready",   32'(move_ready), 32'h0);
    chk("mr_outs",    32'({illegal, game_over, winner, draw, timeout}), 32'h0);
    start = 1'b1; tick(); start = 1'b0;
    chk("mr_new_turn",  32'(turn),       32'h1);
    chk("mr_new_ready", 32'(move_ready), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
